ikari_sprite_line_buffer: RTL and testbench

Double-banked sprite line buffer sitting directly downstream of the front sprite layer. It consumes the serialised sprite pixel stream (priority bit, colour bank and 3-bit pixel code) together with each sprite's 9-bit X start position, and accumulates one scanline in the write bank. At each line boundary the banks swap, and the previous line is read out by horizontal position to the video mixer, with each location cleared after it is read.

---
 rtl/ikari_video_pkg.sv | 25 ++
 rtl/spr_lbuf_bank.sv | 31 +++
 rtl/ikari_sprite_line_buffer.sv | 190 +++++++++++++++++++
 tb/tb_ikari_sprite_line_buffer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ikari_video_pkg.sv
// Shared types and constants for the Ikari sprite/video path.
// Pixel words are {prio, bank[3:0], code[2:0]}; code 3'b111 is transparent.
package ikari_video_pkg;

  localparam int LBUF_XW = 9;
  localparam int PIX_W   = 8;

  localparam logic [PIX_W-1:0] PIX_EMPTY = 8'hFF;

  typedef struct packed {
    logic       prio;
    logic [3:0] bank;
    logic [2:0] code;
  } spr_pix_t;

  typedef enum logic {
    INIT,
    RUN
  } lbuf_state_t;

  function automatic logic is_transparent(input logic [2:0] code);
    return code == 3'b111;
  endfunction

endpackage

// File: rtl/spr_lbuf_bank.sv
// One line-buffer bank: dual-port synchronous RAM, port A write-only,
// port B read with optional write in the same cycle (old data returned).
module spr_lbuf_bank #(
  parameter int AW = 9,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  input  logic          b_en,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic [DW-1:0] b_rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] b_rdata_q;

  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wdata;
    if (b_en) begin
      b_rdata_q <= mem[b_addr];
      if (b_we) mem[b_addr] <= b_wdata;
    end
  end

  assign b_rdata = b_rdata_q;

endmodule

// File: rtl/ikari_sprite_line_buffer.sv
// Double-banked sprite line buffer with clear-after-read display side.
// SPR_FIRST_WINS_EN: read-modify-write so the first-drawn opaque pixel wins.
module ikari_sprite_line_buffer
  import ikari_video_pkg::*;
#(
  parameter int XW = LBUF_XW,
  parameter int PW = PIX_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          line_swap,
  input  logic          wr_x_load,
  input  logic [XW-1:0] wr_x,
  input  logic          wr_cen,
  input  logic [PW-1:0] wr_pix,
  input  logic          rd_cen,
  input  logic [XW-1:0] rd_x,
  output logic [PW-1:0] rd_pix,
  output logic          rd_valid,
  output logic          init_done,
  output logic          bank_sel
);

  localparam logic [PW-1:0] EMPTY = '1;

  lbuf_state_t   state_q, state_d;
  logic [XW-1:0] init_cnt_q, init_cnt_d;
  logic [XW-1:0] xcnt_q, xcnt_d;
  logic          bank_sel_q, bank_sel_d;
  logic          init_done_q, init_done_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_bank_q, rd_bank_d;
  logic [PW-1:0] rd_hold_q, rd_hold_d;
  logic [XW-1:0] wr_addr;
  logic          wr_fire;

  logic          a_we    [2];
  logic [XW-1:0] a_addr  [2];
  logic [PW-1:0] a_wdata [2];
  logic          b_en    [2];
  logic          b_we    [2];
  logic [XW-1:0] b_addr  [2];
  logic [PW-1:0] b_wdata [2];
  logic [PW-1:0] b_rdata [2];

`ifdef SPR_FIRST_WINS_EN
  logic          req_v_q, req_v_d;
  logic          req_bank_q, req_bank_d;
  logic [XW-1:0] req_addr_q, req_addr_d;
  logic [PW-1:0] req_pix_q, req_pix_d;
`endif

  assign rd_pix    = rd_pend_q ? b_rdata[rd_bank_q] : rd_hold_q;
  assign rd_valid  = !is_transparent(rd_pix[2:0]);
  assign init_done = init_done_q;
  assign bank_sel  = bank_sel_q;

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    xcnt_d      = xcnt_q;
    bank_sel_d  = bank_sel_q;
    rd_pend_d   = 1'b0;
    rd_bank_d   = rd_bank_q;
    rd_hold_d   = rd_pix;
    wr_addr     = wr_x_load ? wr_x : xcnt_q;
    wr_fire     = 1'b0;
    unique case (state_q)
      INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (&init_cnt_q) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end
      end
      RUN: begin
        if (wr_x_load) xcnt_d = wr_x;
        if (wr_cen) begin
          xcnt_d  = wr_addr + 1'b1;
          wr_fire = !is_transparent(wr_pix[2:0]);
        end
        if (line_swap) bank_sel_d = ~bank_sel_q;
        if (rd_cen) begin
          rd_pend_d = 1'b1;
          rd_bank_d = ~bank_sel_q;
        end
      end
      default: ;
    endcase
  end

`ifdef SPR_FIRST_WINS_EN
  always_comb begin
    req_v_d    = wr_fire;
    req_bank_d = bank_sel_q;
    req_addr_d = wr_addr;
    req_pix_d  = wr_pix;
  end
`endif

  // Write side owns port A; display side owns port B of the other bank.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      a_we[b]    = 1'b0;
      a_addr[b]  = wr_addr;
      a_wdata[b] = wr_pix;
      b_en[b]    = 1'b0;
      b_we[b]    = 1'b0;
      b_addr[b]  = rd_x;
      b_wdata[b] = EMPTY;
    end
    if (state_q == INIT) begin
      for (int b = 0; b < 2; b++) begin
        a_we[b]    = 1'b1;
        a_addr[b]  = init_cnt_q;
        a_wdata[b] = EMPTY;
      end
    end else begin
      b_en[~bank_sel_q] = rd_cen;
      b_we[~bank_sel_q] = rd_cen;
`ifdef SPR_FIRST_WINS_EN
      b_en[bank_sel_q]   = wr_fire;
      b_addr[bank_sel_q] = wr_addr;
      a_we[req_bank_q]   = req_v_q &&
        is_transparent(b_rdata[req_bank_q][2:0]);
      a_addr[req_bank_q]  = req_addr_q;
      a_wdata[req_bank_q] = req_pix_q;
`else
      a_we[bank_sel_q] = wr_fire;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      xcnt_q      <= '0;
      bank_sel_q  <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      rd_hold_q   <= EMPTY;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      xcnt_q      <= xcnt_d;
      bank_sel_q  <= bank_sel_d;
      rd_pend_q   <= rd_pend_d;
      rd_bank_q   <= rd_bank_d;
      rd_hold_q   <= rd_hold_d;
    end
  end

`ifdef SPR_FIRST_WINS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      req_v_q    <= 1'b0;
      req_bank_q <= 1'b0;
      req_addr_q <= '0;
      req_pix_q  <= EMPTY;
    end else begin
      req_v_q    <= req_v_d;
      req_bank_q <= req_bank_d;
      req_addr_q <= req_addr_d;
      req_pix_q  <= req_pix_d;
    end
  end
`endif

  for (genvar g = 0; g < 2; g++) begin : g_bank
    spr_lbuf_bank #(
      .AW (XW),
      .DW (PW)
    ) u_bank (
      .clk     (clk),
      .a_we    (a_we[g]),
      .a_addr  (a_addr[g]),
      .a_wdata (a_wdata[g]),
      .b_en    (b_en[g]),
      .b_we    (b_we[g]),
      .b_addr  (b_addr[g]),
      .b_wdata (b_wdata[g]),
      .b_rdata (b_rdata[g])
    );
  end

endmodule

// File: tb/tb_ikari_sprite_line_buffer.sv
// Directed bench for ikari_sprite_line_buffer.
// Expected values are hand-computed {rd_valid, rd_pix} words.
module tb_ikari_sprite_line_buffer;

  localparam int XW = 9;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          line_swap = 1'b0;
  logic          wr_x_load = 1'b0;
  logic [XW-1:0] wr_x = '0;
  logic          wr_cen = 1'b0;
  logic [PW-1:0] wr_pix = '0;
  logic          rd_cen = 1'b0;
  logic [XW-1:0] rd_x = '0;
  logic [PW-1:0] rd_pix;
  logic          rd_valid;
  logic          init_done;
  logic          bank_sel;

  int checks = 0;
  int errors = 0;
  logic [8:0] v;

  always #5 clk = ~clk;

  ikari_sprite_line_buffer #(
    .XW (XW),
    .PW (PW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .line_swap (line_swap),
    .wr_x_load (wr_x_load),
    .wr_x      (wr_x),
    .wr_cen    (wr_cen),
    .wr_pix    (wr_pix),
    .rd_cen    (rd_cen),
    .rd_x      (rd_x),
    .rd_pix    (rd_pix),
    .rd_valid  (rd_valid),
    .init_done (init_done),
    .bank_sel  (bank_sel)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic swap();
    line_swap = 1'b1;
    tick();
    line_swap = 1'b0;
  endtask

  task automatic load(input logic [XW-1:0] x);
    wr_x      = x;
    wr_x_load = 1'b1;
    tick();
    wr_x_load = 1'b0;
  endtask

  task automatic pix(input logic [PW-1:0] p);
    wr_pix = p;
    wr_cen = 1'b1;
    tick();
    wr_cen = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [XW-1:0] x,
                        input logic [8:0] exp);
    rd_x   = x;
    rd_cen = 1'b1;
    tick();
    rd_cen = 1'b0;
    v = {rd_valid, rd_pix};
    check(tag, v, exp);
  endtask

  task automatic reset_seq(input string tag);
    rst = 1'b1;
    tick();
    check({tag, "_rst_state"},
          {init_done, bank_sel, rd_valid, rd_pix}, 11'h0FF);
    rst    = 1'b0;
    wr_cen = 1'b0;
    ticks(511);
    check({tag, "_init_511"}, init_done, 1'b0);
    tick();
    check({tag, "_init_512"}, init_done, 1'b1);
  endtask

  initial begin
    reset_seq("init");

    for (int i = 0; i < 512; i++) rd_chk("init_bank1", i[XW-1:0], 9'h0FF);
    swap();
    check("swap_bank_sel", bank_sel, 1'b1);
    for (int i = 0; i < 512; i++) rd_chk("init_bank0", i[XW-1:0], 9'h0FF);
    swap();

    load(9'd100);
    pix(8'h12);
    pix(8'hFF);
    pix(8'h34);
    ticks(3);
    swap();
    rd_chk("line_x100", 9'd100, 9'h112);
    rd_chk("line_x101", 9'd101, 9'h0FF);
    rd_chk("line_x102", 9'd102, 9'h134);
    tick();
    v = {rd_valid, rd_pix};
    check("line_hold", v, 9'h134);
    rd_chk("line_clear", 9'd100, 9'h0FF);

    load(9'd510);
    pix(8'h01);
    pix(8'h02);
    pix(8'h03);
    pix(8'h04);
    ticks(3);
    swap();
    rd_chk("wrap_x510", 9'd510, 9'h101);
    rd_chk("wrap_x511", 9'd511, 9'h102);
    rd_chk("wrap_x0", 9'd0, 9'h103);
    rd_chk("wrap_x1", 9'd1, 9'h104);

    load(9'd50);
    pix(8'h21);
    ticks(3);
    wr_x      = 9'd50;
    wr_x_load = 1'b1;
    pix(8'h45);
    wr_x_load = 1'b0;
    pix(8'h46);
    ticks(3);
    swap();
`ifdef SPR_FIRST_WINS_EN
    rd_chk("overlap_x50", 9'd50, 9'h121);
`else
    rd_chk("overlap_x50", 9'd50, 9'h145);
`endif
    rd_chk("load_cen_x51", 9'd51, 9'h146);

    load(9'd7);
    line_swap = 1'b1;
    pix(8'h55);
    line_swap = 1'b0;
    ticks(3);
    check("inflight_bank_sel", bank_sel, 1'b0);
    rd_chk("inflight_old_wbank", 9'd7, 9'h155);
    swap();
    rd_chk("inflight_other", 9'd7, 9'h0FF);

    load(9'd300);
    pix(8'h13);
    ticks(3);
    load(9'd200);
    pix(8'h11);
    wr_pix = 8'h22;
    wr_cen = 1'b1;
    reset_seq("midline");

    pix(8'h66);
    ticks(3);
    swap();
    rd_chk("post_rst_x0", 9'd0, 9'h166);
    rd_chk("post_rst_b0_x300", 9'd300, 9'h0FF);
    rd_chk("post_rst_b0_x200", 9'd200, 9'h0FF);
    rd_chk("post_rst_b0_x201", 9'd201, 9'h0FF);
    swap();
    rd_chk("post_rst_b1_x300", 9'd300, 9'h0FF);
    rd_chk("post_rst_b1_x200", 9'd200, 9'h0FF);
    rd_chk("post_rst_b1_x201", 9'd201, 9'h0FF);
    rd_chk("post_rst_b1_x0", 9'd0, 9'h0FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
